// File: rtl/jtag_tap_slave_if.sv
// JTAG serial link between the scanning master and the TAP responder (tck/trst_n stay plain ports).
interface jtag_tap_slave_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (
    output tms,
    output tdi,
    input  tdo,
    input  tdo_oe
  );

  modport slave (
    input  tms,
    input  tdi,
    output tdo,
    output tdo_oe
  );
endinterface

// File: rtl/jtag_tap_slave.sv
// IEEE 1149.1-style TAP responder: 16-state FSM, 4-bit IR, BYPASS/IDCODE/USER data registers.
// Optional JTAG_TAP_SCAN_COUNT_EN adds a saturating USER-update counter readable via SCANCNT.
module jtag_tap_slave #(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5F,
  parameter int unsigned DR_WIDTH   = 32,
  parameter logic [3:0]  IR_CAPTURE = 4'b0101
) (
  input  logic                tck,
  input  logic                trst_n,
  jtag_tap_slave_if.slave     jtag,
  input  logic [DR_WIDTH-1:0] user_capture_i,
  output logic [DR_WIDTH-1:0] user_data_o,
  output logic                user_update_o,
  output logic [3:0]          tap_state_o,
  output logic [3:0]          ir_o
);

  typedef enum logic [3:0] {
    StTlr   = 4'hF, StRti   = 4'hC,
    StSelDr = 4'h7, StCapDr = 4'h6, StShDr  = 4'h2, StEx1Dr = 4'h1,
    StPauDr = 4'h3, StEx2Dr = 4'h0, StUpdDr = 4'h5,
    StSelIr = 4'h4, StCapIr = 4'hE, StShIr  = 4'hA, StEx1Ir = 4'h9,
    StPauIr = 4'hB, StEx2Ir = 4'h8, StUpdIr = 4'hD
  } tap_state_e;

  localparam logic [3:0] IrIdcode  = 4'b0001;
  localparam logic [3:0] IrUser    = 4'b1000;
  localparam logic [3:0] IrScancnt = 4'b0010;

  tap_state_e          state_q, state_d;
  logic [3:0]          ir_q, ir_sr_q;
  logic                bypass_q;
  logic [31:0]         id_sr_q, id_shift;
  logic [DR_WIDTH-1:0] user_sr_q, user_shift, user_data_q;
  logic                tdo_q, tdo_d, tdo_oe_q;
  logic                tdi_s, tms_s;
  logic                sel_id, sel_user, sel_cnt;

  // Undriven or unknown tdi reads as 0.
  assign tdi_s = (jtag.tdi === 1'b1);
  assign tms_s = jtag.tms;

  assign sel_id   = (ir_q == IrIdcode);
  assign sel_user = (ir_q == IrUser);
`ifdef JTAG_TAP_SCAN_COUNT_EN
  assign sel_cnt  = (ir_q == IrScancnt);
`else
  assign sel_cnt  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = tms_s ? StTlr   : StRti;
      StRti:   state_d = tms_s ? StSelDr : StRti;
      StSelDr: state_d = tms_s ? StSelIr : StCapDr;
      StCapDr: state_d = tms_s ? StEx1Dr : StShDr;
      StShDr:  state_d = tms_s ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms_s ? StUpdDr : StPauDr;
      StPauDr: state_d = tms_s ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = tms_s ? StUpdDr : StShDr;
      StUpdDr: state_d = tms_s ? StSelDr : StRti;
      StSelIr: state_d = tms_s ? StTlr   : StCapIr;
      StCapIr: state_d = tms_s ? StEx1Ir : StShIr;
      StShIr:  state_d = tms_s ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms_s ? StUpdIr : StPauIr;
      StPauIr: state_d = tms_s ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = tms_s ? StUpdIr : StShIr;
      StUpdIr: state_d = tms_s ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  // Shift-right images; written this way so DR_WIDTH = 1 needs no special case.
  always_comb begin
    id_shift               = id_sr_q >> 1;
    id_shift[31]           = tdi_s;
    user_shift             = user_sr_q >> 1;
    user_shift[DR_WIDTH-1] = tdi_s;
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= StTlr;
      ir_q        <= IrIdcode;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      id_sr_q     <= '0;
      user_sr_q   <= '0;
      user_data_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_d == StTlr) begin
        ir_q <= IrIdcode;
      end else if (state_q == StUpdIr) begin
        ir_q <= ir_sr_q;
      end

      if (state_q == StCapIr) begin
        ir_sr_q <= IR_CAPTURE;
      end else if (state_q == StShIr) begin
        ir_sr_q <= {tdi_s, ir_sr_q[3:1]};
      end

      if (state_q == StCapDr) begin
        if (sel_id)   id_sr_q   <= IDCODE_VAL;
        if (sel_user) user_sr_q <= user_capture_i;
        bypass_q <= 1'b0;
      end else if (state_q == StShDr) begin
        if (sel_id)   id_sr_q   <= id_shift;
        if (sel_user) user_sr_q <= user_shift;
        bypass_q <= tdi_s;
      end

      // Load on entry so user_data_o is already valid while user_update_o is high.
      if (state_d == StUpdDr && sel_user) begin
        user_data_q <= user_sr_q;
      end
    end
  end

`ifdef JTAG_TAP_SCAN_COUNT_EN
  logic [15:0] cnt_q, cnt_sr_q;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      cnt_q    <= '0;
      cnt_sr_q <= '0;
    end else begin
      if (state_d == StTlr) begin
        cnt_q <= '0;
      end else if (state_d == StUpdDr && sel_user && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (state_q == StCapDr && sel_cnt) begin
        cnt_sr_q <= cnt_q;
      end else if (state_q == StShDr && sel_cnt) begin
        cnt_sr_q <= {tdi_s, cnt_sr_q[15:1]};
      end
    end
  end
`endif

  always_comb begin
    tdo_d = 1'b0;
    if (state_q == StShIr) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == StShDr) begin
      if (sel_id) begin
        tdo_d = id_sr_q[0];
      end else if (sel_user) begin
        tdo_d = user_sr_q[0];
`ifdef JTAG_TAP_SCAN_COUNT_EN
      end else if (sel_cnt) begin
        tdo_d = cnt_sr_q[0];
`endif
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  // Falling-edge launch keeps tdo stable across the master's rising-edge sample.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= (state_q == StShDr) || (state_q == StShIr);
    end
  end

  assign jtag.tdo      = tdo_q;
  assign jtag.tdo_oe   = tdo_oe_q;
  assign user_data_o   = user_data_q;
  assign user_update_o = (state_q == StUpdDr) && sel_user;
  assign tap_state_o   = state_q;
  assign ir_o          = ir_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed bench for jtag_tap_slave: bit-level TAP driving with hand-computed expectations.
module tb_jtag_tap_slave;

  logic        tck = 1'b0;
  logic        trst_n;
  logic [31:0] user_capture;
  logic [31:0] user_data;
  logic        user_update;
  logic [3:0]  tap_state;
  logic [3:0]  ir;
  int          errors = 0;
  int          checks = 0;
  int          upd_cnt = 0;

  jtag_tap_slave_if jtag ();

  jtag_tap_slave #(
    .IDCODE_VAL (32'h1000_0A5F),
    .DR_WIDTH   (32),
    .IR_CAPTURE (4'b0101)
  ) dut (
    .tck            (tck),
    .trst_n         (trst_n),
    .jtag           (jtag),
    .user_capture_i (user_capture),
    .user_data_o    (user_data),
    .user_update_o  (user_update),
    .tap_state_o    (tap_state),
    .ir_o           (ir)
  );

  always #10 tck = ~tck;

  // UPD_DR spans exactly one falling edge, so this counts update pulses.
  always @(negedge tck) if (user_update) upd_cnt <= upd_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One tck: drive tms/tdi after the falling edge, capture what the master sees at the rising edge.
  task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_s, output logic oe_s);
    @(negedge tck);
    #2;
    jtag.tms = tms_v;
    jtag.tdi = tdi_v;
    tdo_s    = jtag.tdo;
    oe_s     = jtag.tdo_oe;
    @(posedge tck);
    #1;
  endtask

  task automatic step(input logic tms_v);
    logic o, e;
    tick(tms_v, 1'b0, o, e);
  endtask

  // From RTI back to RTI.
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] out);
    logic o, e;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, val[i], o, e);
      out[i] = o;
    end
    step(1'b1);
    step(1'b0);
  endtask

  // From RTI back to RTI; oe_n counts tdo_oe over every sampled edge of the scan.
  task automatic scan_dr(input int n, input logic [63:0] val, output logic [63:0] out,
                         output int oe_n);
    logic o, e;
    out  = '0;
    oe_n = 0;
    tick(1'b1, 1'b0, o, e); oe_n += int'(e);
    tick(1'b0, 1'b0, o, e); oe_n += int'(e);
    tick(1'b0, 1'b0, o, e); oe_n += int'(e);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, val[i], o, e);
      out[i] = o;
      oe_n += int'(e);
    end
    tick(1'b1, 1'b0, o, e); oe_n += int'(e);
    tick(1'b0, 1'b0, o, e); oe_n += int'(e);
  endtask

  initial begin
    logic [63:0] dout;
    logic [3:0]  iout;
    int          oe_n;
    int          u0;

    jtag.tms     = 1'b1;
    jtag.tdi     = 1'b0;
    trst_n       = 1'b0;
    user_capture = 32'hDEAD_BEEF;
    #25;
    check("rst_state", 64'(tap_state), 64'hF);
    check("rst_ir", 64'(ir), 64'h1);
    check("rst_user_data", 64'(user_data), 64'h0);
    check("rst_update", 64'(user_update), 64'h0);
    check("rst_tdo", 64'(jtag.tdo), 64'h0);
    check("rst_tdo_oe", 64'(jtag.tdo_oe), 64'h0);
    trst_n = 1'b1;

    step(1'b0);
    check("rti_state", 64'(tap_state), 64'hC);

    // IDCODE after reset
    scan_dr(32, 64'h0, dout, oe_n);
    check("idcode", dout, 64'h1000_0A5F);
    check("idcode_oe_cnt", 64'(oe_n), 64'd32);
    check("idcode_end_state", 64'(tap_state), 64'hC);

    // BYPASS: one-bit delay, 0xB3 -> {0xB3[6:0], 0}
    scan_ir(4'hF, iout);
    check("ir_capture_f", 64'(iout), 64'h5);
    check("ir_bypass", 64'(ir), 64'hF);
    u0 = upd_cnt;
    scan_dr(8, 64'hB3, dout, oe_n);
    check("bypass_data", dout, 64'h66);
    check("bypass_no_update", 64'(upd_cnt - u0), 64'd0);

    // USER capture / update
    scan_ir(4'h8, iout);
    check("ir_user", 64'(ir), 64'h8);
    u0 = upd_cnt;
    scan_dr(32, 64'hA5A5_1234, dout, oe_n);
    check("user_capture", dout, 64'hDEAD_BEEF);
    check("user_data", 64'(user_data), 64'hA5A5_1234);
    check("user_update_pulses", 64'(upd_cnt - u0), 64'd1);

    // tms=1 x5 from SH_DR; the standard path crosses UPD_DR after 4 shifts of 0 into DEADBEEF
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("sh_dr_state", 64'(tap_state), 64'h2);
    u0 = upd_cnt;
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    check("tms_reset_state", 64'(tap_state), 64'hF);
    check("tms_reset_ir", 64'(ir), 64'h1);
    check("tms_reset_user_data", 64'(user_data), 64'h0DEA_DBEE);
    check("tms_reset_update", 64'(upd_cnt - u0), 64'd1);
    step(1'b1);
    check("tlr_hold_user_data", 64'(user_data), 64'h0DEA_DBEE);
    step(1'b0);
    scan_ir(4'h6, iout);
    check("ir_capture_6", 64'(iout), 64'h5);
    check("ir_6", 64'(ir), 64'h6);
    scan_dr(8, 64'hB3, dout, oe_n);
    check("undef_op_bypass", dout, 64'h66);

    // Async reset mid SH_IR
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("sh_ir_state", 64'(tap_state), 64'hA);
    step(1'b0);
    step(1'b0);
    #3;
    trst_n = 1'b0;
    #1;
    check("abort_state", 64'(tap_state), 64'hF);
    check("abort_tdo", 64'(jtag.tdo), 64'h0);
    check("abort_tdo_oe", 64'(jtag.tdo_oe), 64'h0);
    check("abort_ir", 64'(ir), 64'h1);
    check("abort_user_data", 64'(user_data), 64'h0);
    #2;
    trst_n = 1'b1;
    step(1'b1);
    step(1'b0);
    scan_dr(32, 64'h0, dout, oe_n);
    check("idcode_after_abort", dout, 64'h1000_0A5F);

    // SCANCNT (or BYPASS when the counter is not built)
    scan_ir(4'h8, iout);
    for (int i = 0; i < 3; i++) scan_dr(32, 64'(i), dout, oe_n);
    check("user_data_last", 64'(user_data), 64'h2);
    scan_ir(4'h2, iout);
    check("ir_scancnt", 64'(ir), 64'h2);
    scan_dr(16, 64'hFFFF, dout, oe_n);
`ifdef JTAG_TAP_SCAN_COUNT_EN
    check("scancnt", dout, 64'd3);
`else
    check("scancnt_as_bypass", dout, 64'hFFFE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
